// File: rtl/local_ni_pkg.sv
// Shared types and constants for the local network-interface injector.
package local_ni_pkg;

    localparam int FLIT_W   = 16;
    localparam int CREDIT_W = 4;

    // Header flit layout: {y, x}
    localparam int DEST_Y_MSB = 15;
    localparam int DEST_Y_LSB = 8;
    localparam int DEST_X_MSB = 7;
    localparam int DEST_X_LSB = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HEAD = 2'd1,
        BODY = 2'd2
    } ni_state_t;

endpackage

// File: rtl/ni_credit_tracker.sv
// Saturating credit counter for the router's local input buffer, with a
// sticky flag raised when a credit arrives while the count is already full.
module ni_credit_tracker
    import local_ni_pkg::*;
#(
    parameter int BUF_DEPTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                send,
    input  logic                credit_ret,
    output logic [CREDIT_W-1:0] credits,
    output logic                credit_err
);

    localparam logic [CREDIT_W-1:0] FULL = CREDIT_W'(BUF_DEPTH);

    // Count down on a sent flit, up on a returned credit; both cancel out.
    always_ff @(posedge clk) begin
        if (reset) begin
            credits    <= FULL;
            credit_err <= 1'b0;
        end else begin
            unique case ({send, credit_ret})
                2'b10: credits <= credits - 1'b1;
                2'b01: begin
                    if (credits == FULL) credit_err <= 1'b1;
                    else                 credits    <= credits + 1'b1;
                end
                default: credits <= credits;
            endcase
        end
    end

endmodule

// File: rtl/local_ni_injector.sv
// Local NI injector: accepts a packet from the core and serializes it into a
// header flit plus PAYLOAD_FLITS body flits, gated by router credits.
// Optional packet counter output enabled by `LOCAL_NI_PKT_COUNT_EN.
module local_ni_injector
    import local_ni_pkg::*;
#(
    parameter int PAYLOAD_FLITS = 3,
    parameter int BUF_DEPTH     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          core_valid_i,
    output logic                          core_ready_o,
    input  logic [FLIT_W-1:0]             core_dest_i,
    input  logic [FLIT_W*PAYLOAD_FLITS-1:0] core_payload_i,
    output logic [FLIT_W-1:0]             l_data_o,
    output logic                          l_valid_o,
    input  logic                          l_credit_i,
    output logic [CREDIT_W-1:0]           credits_o,
    output logic                          busy_o,
    output logic                          credit_err_o
`ifdef LOCAL_NI_PKT_COUNT_EN
    ,
    output logic [15:0]                   pkt_count_o
`endif
);

    localparam logic [3:0] LAST = 4'(PAYLOAD_FLITS - 1);

    ni_state_t                              state, state_nxt;
    logic [3:0]                             idx, idx_nxt;
    logic [FLIT_W-1:0]                      dest_q;
    logic [PAYLOAD_FLITS-1:0][FLIT_W-1:0]   pay_q;
    logic [FLIT_W-1:0]                      body_flit;
    logic                                   send;
    logic                                   accept;

    // A flit goes out whenever a packet is in flight and a credit is held;
    // reset masks it so nothing escapes while the router is being reset.
    assign send         = (state != IDLE) && (credits_o != '0) && !reset;
    assign l_valid_o    = send;
    assign core_ready_o = (state == IDLE);
    assign busy_o       = (state != IDLE);
    assign accept       = core_valid_i && core_ready_o;

    ni_credit_tracker #(.BUF_DEPTH(BUF_DEPTH)) u_credit (
        .clk        (clk),
        .reset      (reset),
        .send       (send),
        .credit_ret (l_credit_i),
        .credits    (credits_o),
        .credit_err (credit_err_o)
    );

    // State, index and the packet latched at the core handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            idx    <= '0;
            dest_q <= '0;
            pay_q  <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (accept) begin
                dest_q <= core_dest_i;
                pay_q  <= core_payload_i;
            end
        end
    end

    // Body flit select by index (compare-based so the index stays 4 bits).
    always_comb begin
        body_flit = '0;
        for (int k = 0; k < PAYLOAD_FLITS; k++)
            if (idx == 4'(k)) body_flit = pay_q[k];
    end

    // Next state, index and flit mux; state holds while credits are zero.
    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        l_data_o  = '0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = HEAD;
                    idx_nxt   = '0;
                end
            end
            HEAD: begin
                l_data_o = dest_q;
                if (send) begin
                    state_nxt = BODY;
                    idx_nxt   = '0;
                end
            end
            BODY: begin
                l_data_o = body_flit;
                if (send) begin
                    if (idx == LAST) begin
                        state_nxt = IDLE;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

`ifdef LOCAL_NI_PKT_COUNT_EN
    // Count packets on the cycle their last body flit leaves; wraps naturally.
    always_ff @(posedge clk) begin
        if (reset)
            pkt_count_o <= '0;
        else if (send && (state == BODY) && (idx == LAST))
            pkt_count_o <= pkt_count_o + 16'd1;
    end
`endif

endmodule

// File: tb/tb_local_ni_injector.sv
// Directed bench for local_ni_injector with a flit scoreboard.
module tb_local_ni_injector;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_valid_i;
    logic        core_ready_o;
    logic [15:0] core_dest_i;
    logic [47:0] core_payload_i;
    logic [15:0] l_data_o;
    logic        l_valid_o;
    logic        l_credit_i;
    logic [3:0]  credits_o;
    logic        busy_o;
    logic        credit_err_o;
`ifdef LOCAL_NI_PKT_COUNT_EN
    logic [15:0] pkt_count;
`endif

    int total = 0;
    int bad   = 0;
    int flits = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    local_ni_injector #(.PAYLOAD_FLITS(3), .BUF_DEPTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .core_valid_i   (core_valid_i),
        .core_ready_o   (core_ready_o),
        .core_dest_i    (core_dest_i),
        .core_payload_i (core_payload_i),
        .l_data_o       (l_data_o),
        .l_valid_o      (l_valid_o),
        .l_credit_i     (l_credit_i),
        .credits_o      (credits_o),
        .busy_o         (busy_o),
        .credit_err_o   (credit_err_o)
`ifdef LOCAL_NI_PKT_COUNT_EN
        ,
        .pkt_count_o    (pkt_count)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Push the expected flit stream, then hold valid until the handshake edge.
    task automatic send_pkt(input logic [15:0] d, input logic [47:0] p);
        exp_q.push_back(d);
        exp_q.push_back(p[15:0]);
        exp_q.push_back(p[31:16]);
        exp_q.push_back(p[47:32]);
        core_dest_i    = d;
        core_payload_i = p;
        core_valid_i   = 1'b1;
        for (int i = 0; i < 40 && !core_ready_o; i++) step();
        chk("hs_ready", core_ready_o, 1);
        step();
        core_valid_i   = 1'b0;
        core_dest_i    = 16'hDEAD;
        core_payload_i = 48'hBAD0_BAD1_BAD2;
    endtask

    // Scoreboard: every valid flit must match the next expected one.
    always @(negedge clk) begin
        if (l_valid_o) begin
            flits++;
            if (exp_q.size() == 0) chk("sb_extra", l_data_o, 32'hFFFF_FFFF);
            else                   chk("sb_flit", l_data_o, exp_q.pop_front());
        end
    end

    initial begin
        reset = 1'b1; core_valid_i = 1'b0; core_dest_i = '0;
        core_payload_i = '0; l_credit_i = 1'b0;

        // Reset values
        step(); step();
        reset = 1'b0;
        chk("rst_ready", core_ready_o, 1);
        chk("rst_valid", l_valid_o, 0);
        chk("rst_credits", credits_o, 8);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", credit_err_o, 0);
        chk("rst_data", l_data_o, 0);

        // Single packet: header at t+1, bodies back to back, ready at t+5
        send_pkt(16'h0102, {16'hCCCC, 16'hBBBB, 16'hAAAA});
        chk("p1_v1", l_valid_o, 1); chk("p1_d1", l_data_o, 16'h0102);
        chk("p1_busy", busy_o, 1);  chk("p1_nrdy", core_ready_o, 0);
        step(); chk("p1_v2", l_valid_o, 1); chk("p1_d2", l_data_o, 16'hAAAA);
        step(); chk("p1_v3", l_valid_o, 1); chk("p1_d3", l_data_o, 16'hBBBB);
        step(); chk("p1_v4", l_valid_o, 1); chk("p1_d4", l_data_o, 16'hCCCC);
        step();
        chk("p1_ready", core_ready_o, 1); chk("p1_valid", l_valid_o, 0);
        chk("p1_credits", credits_o, 4);
`ifdef LOCAL_NI_PKT_COUNT_EN
        chk("p1_count", pkt_count, 1);
`endif

        // Credit exhaustion
        send_pkt(16'h0203, {16'h0003, 16'h0002, 16'h0001});
        step(); step(); step(); step();
        chk("ex_credits", credits_o, 0); chk("ex_ready", core_ready_o, 1);
        send_pkt(16'h0304, {16'h3C3C, 16'h3B3B, 16'h3A3A});
        chk("ex_stall_v", l_valid_o, 0); chk("ex_stall_d", l_data_o, 16'h0304);
        chk("ex_stall_busy", busy_o, 1);
        step();
        chk("ex_stall2_v", l_valid_o, 0);
        l_credit_i = 1'b1;
        step();
        l_credit_i = 1'b0;
        chk("ex_ret_v", l_valid_o, 1); chk("ex_ret_d", l_data_o, 16'h0304);
        chk("ex_ret_cr", credits_o, 1);
        step();
        chk("ex_re_v", l_valid_o, 0); chk("ex_re_d", l_data_o, 16'h3A3A);
        chk("ex_re_cr", credits_o, 0);

        // Reset mid-packet (cycle after header was sent)
        reset = 1'b1;
        chk("mid_rst_v", l_valid_o, 0);
        step();
        reset = 1'b0;
        exp_q.delete();
        chk("mid_v", l_valid_o, 0); chk("mid_cr", credits_o, 8);
        chk("mid_ready", core_ready_o, 1); chk("mid_busy", busy_o, 0);

        // New packet; simultaneous send and return at credits 5
        send_pkt(16'h0405, {16'h3333, 16'h2222, 16'h1111});
        chk("sim_d1", l_data_o, 16'h0405); chk("sim_c1", credits_o, 8);
        step(); chk("sim_c2", credits_o, 7);
        step(); chk("sim_c3", credits_o, 6);
        step();
        chk("sim_c4", credits_o, 5); chk("sim_v4", l_valid_o, 1);
        chk("sim_d4", l_data_o, 16'h3333);
        l_credit_i = 1'b1;
        step();
        l_credit_i = 1'b0;
        chk("sim_hold", credits_o, 5); chk("sim_ready", core_ready_o, 1);
        chk("sim_err", credit_err_o, 0);
`ifdef LOCAL_NI_PKT_COUNT_EN
        chk("sim_count", pkt_count, 1);
`endif

        // Credit overflow while idle
        l_credit_i = 1'b1;
        step(); step(); step();
        chk("ov_full", credits_o, 8); chk("ov_noerr", credit_err_o, 0);
        step();
        l_credit_i = 1'b0;
        chk("ov_sat", credits_o, 8); chk("ov_err", credit_err_o, 1);
        step(); step(); step();
        chk("ov_sticky", credit_err_o, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("ov_clr", credit_err_o, 0); chk("ov_cr", credits_o, 8);

        chk("sb_empty", exp_q.size(), 0);
        chk("flit_total", flits, 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
